// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: bundles the decode-side offer, the EX-side handshake and
// the MEM/WB forwarding taps seen by the ID/EX pipeline register.
//   master : driver side (decode, hazard sources, downstream ALU acceptor)
//   slave  : the id_ex_stage itself
// Signal names match the stage's external port names so that existing
// bench/top-level hookups map one-to-one.
interface id_ex_stage_if #(
    parameter int unsigned WIDTH = 64
);
    // Decode side
    logic             id_valid;
    logic             id_ready;
    logic [WIDTH-1:0] id_pc;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [WIDTH-1:0] id_rs1_data;
    logic [WIDTH-1:0] id_rs2_data;
    logic [WIDTH-1:0] id_imm;
    logic             id_use_pc;
    logic             id_use_imm;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       id_alu_control;
    logic [4:0]       id_rd;
    logic             id_reg_write;
    logic             id_is_load;
    logic             flush;
    // Forwarding taps
    logic [4:0]       mem_rd;
    logic             mem_reg_write;
    logic             mem_is_load;
    logic [WIDTH-1:0] mem_result;
    logic [4:0]       wb_rd;
    logic             wb_reg_write;
    logic [WIDTH-1:0] wb_data;
    // EX side
    logic             ex_valid;
    logic             ex_ready;
    logic [WIDTH-1:0] ex_operand_a;
    logic [WIDTH-1:0] ex_operand_b;
    logic [WIDTH-1:0] ex_store_data;
    logic [4:0]       ex_alu_control;
    logic [WIDTH-1:0] ex_pc;
    logic [4:0]       ex_rd;
    logic             ex_reg_write;
    logic             ex_is_load;
    logic             hazard_stall;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_imm,
               id_use_pc, id_use_imm, id_uses_rs1, id_uses_rs2, id_alu_control,
               id_rd, id_reg_write, id_is_load, flush,
               mem_rd, mem_reg_write, mem_is_load, mem_result,
               wb_rd, wb_reg_write, wb_data, ex_ready,
        input  id_ready, ex_valid, ex_operand_a, ex_operand_b, ex_store_data,
               ex_alu_control, ex_pc, ex_rd, ex_reg_write, ex_is_load, hazard_stall
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_imm,
               id_use_pc, id_use_imm, id_uses_rs1, id_uses_rs2, id_alu_control,
               id_rd, id_reg_write, id_is_load, flush,
               mem_rd, mem_reg_write, mem_is_load, mem_result,
               wb_rd, wb_reg_write, wb_data, ex_ready,
        output id_ready, ex_valid, ex_operand_a, ex_operand_b, ex_store_data,
               ex_alu_control, ex_pc, ex_rd, ex_reg_write, ex_is_load, hazard_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the 64-bit ALU.
// One-entry valid/ready stage that captures decoded fields and regfile reads,
// forwards MEM/WB results onto the held operands, stalls on load-use hazards
// and supports a same-cycle flush.
// Ports:
//   clk, rst         rising-edge clock, async active-high reset
//   bus (slave)      decode offer (id_*), flush, MEM/WB forwarding taps,
//                    EX handshake and ALU operands (ex_*), hazard_stall
//   perf_hazard_cnt  saturating count of hazard cycles (IDEX_PERF_CNT_EN only)
// Optional feature macro: IDEX_PERF_CNT_EN (adds CNT_W and perf_hazard_cnt).
module id_ex_stage #(
    parameter int unsigned WIDTH = 64
`ifdef IDEX_PERF_CNT_EN
    , parameter int unsigned CNT_W = 32
`endif
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
`ifdef IDEX_PERF_CNT_EN
    , output logic [CNT_W-1:0] perf_hazard_cnt
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] rs1_data;
        logic [WIDTH-1:0] rs2_data;
        logic [WIDTH-1:0] imm;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       alu_control;
        logic [4:0]       rd;
        logic             use_pc;
        logic             use_imm;
        logic             uses_rs1;
        logic             uses_rs2;
        logic             reg_write;
        logic             is_load;
    } entry_t;

    logic   valid_q, valid_d;
    entry_t entry_q, entry_d;

    logic             mem_hit1, mem_hit2, wb_hit1, wb_hit2;
    logic [WIDTH-1:0] fwd_rs1, fwd_rs2;
    logic             hazard, ex_valid, ex_fire, id_ready, capture;

    // A MEM-stage load has no data yet, so it is excluded from forwarding;
    // the hazard logic stalls instead.
    assign mem_hit1 = bus.mem_reg_write && !bus.mem_is_load && (bus.mem_rd != 5'd0) &&
                      (bus.mem_rd == entry_q.rs1);
    assign mem_hit2 = bus.mem_reg_write && !bus.mem_is_load && (bus.mem_rd != 5'd0) &&
                      (bus.mem_rd == entry_q.rs2);
    assign wb_hit1  = bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == entry_q.rs1);
    assign wb_hit2  = bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == entry_q.rs2);

    always_comb begin
        fwd_rs1 = entry_q.rs1_data;
        if (entry_q.rs1 == 5'd0) fwd_rs1 = '0;
        else if (mem_hit1)       fwd_rs1 = bus.mem_result;
        else if (wb_hit1)        fwd_rs1 = bus.wb_data;

        fwd_rs2 = entry_q.rs2_data;
        if (entry_q.rs2 == 5'd0) fwd_rs2 = '0;
        else if (mem_hit2)       fwd_rs2 = bus.mem_result;
        else if (wb_hit2)        fwd_rs2 = bus.wb_data;
    end

    assign hazard   = valid_q && bus.mem_is_load && bus.mem_reg_write && (bus.mem_rd != 5'd0) &&
                      ((entry_q.uses_rs1 && (bus.mem_rd == entry_q.rs1)) ||
                       (entry_q.uses_rs2 && (bus.mem_rd == entry_q.rs2)));
    assign ex_valid = valid_q && !hazard;
    assign ex_fire  = ex_valid && bus.ex_ready;
    assign id_ready = !valid_q || ex_fire || bus.flush;
    assign capture  = bus.id_valid && id_ready && !bus.flush;

    // Priority: flush > capture (replaces a firing entry) > fire > hold.
    // While holding, a matching WB value is latched so the operand stays
    // correct after that instruction leaves writeback.
    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d             = 1'b1;
            entry_d.pc          = bus.id_pc;
            entry_d.rs1_data    = bus.id_rs1_data;
            entry_d.rs2_data    = bus.id_rs2_data;
            entry_d.imm         = bus.id_imm;
            entry_d.rs1         = bus.id_rs1;
            entry_d.rs2         = bus.id_rs2;
            entry_d.alu_control = bus.id_alu_control;
            entry_d.rd          = bus.id_rd;
            entry_d.use_pc      = bus.id_use_pc;
            entry_d.use_imm     = bus.id_use_imm;
            entry_d.uses_rs1    = bus.id_uses_rs1;
            entry_d.uses_rs2    = bus.id_uses_rs2;
            entry_d.reg_write   = bus.id_reg_write;
            entry_d.is_load     = bus.id_is_load;
        end else if (ex_fire) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            if (wb_hit1) entry_d.rs1_data = bus.wb_data;
            if (wb_hit2) entry_d.rs2_data = bus.wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign bus.id_ready       = id_ready;
    assign bus.ex_valid       = ex_valid;
    assign bus.hazard_stall   = hazard;
    assign bus.ex_operand_a   = entry_q.use_pc  ? entry_q.pc  : fwd_rs1;
    assign bus.ex_operand_b   = entry_q.use_imm ? entry_q.imm : fwd_rs2;
    assign bus.ex_store_data  = fwd_rs2;
    assign bus.ex_alu_control = entry_q.alu_control;
    assign bus.ex_pc          = entry_q.pc;
    assign bus.ex_rd          = entry_q.rd;
    assign bus.ex_reg_write   = entry_q.reg_write;
    assign bus.ex_is_load     = entry_q.is_load;

`ifdef IDEX_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (hazard && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign perf_hazard_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: self-checking bench for id_ex_stage. A transaction-level
// model tracks the held instruction and the architecturally current value of
// its sources; directed scenarios are followed by randomized traffic.
// Optional feature macro: IDEX_PERF_CNT_EN (also checks perf_hazard_cnt).
module tb_id_ex_stage;
    localparam int unsigned W = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_ex_stage_if #(.WIDTH(W)) bus ();

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] perf_hazard_cnt;
    id_ex_stage #(.WIDTH(W), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .bus(bus), .perf_hazard_cnt(perf_hazard_cnt));
`else
    id_ex_stage #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the held instruction and the latest known value of its sources.
    bit          m_valid;
    logic [63:0] m_pc, m_imm, m_v1, m_v2;
    logic [4:0]  m_rs1, m_rs2, m_alu, m_rd;
    bit          m_use_pc, m_use_imm, m_u1, m_u2, m_rw, m_ld;
    longint unsigned m_cnt;

    task automatic model_reset();
        m_valid = 0; m_cnt = 0;
    endtask

    function automatic logic [63:0] src_val(input logic [4:0] r, input logic [63:0] latest);
        if (r == 0) return 64'd0;
        if (bus.mem_reg_write && !bus.mem_is_load && bus.mem_rd == r) return bus.mem_result;
        if (bus.wb_reg_write && bus.wb_rd == r) return bus.wb_data;
        return latest;
    endfunction

    task automatic idle_inputs();
        bus.id_valid = 0; bus.id_pc = '0; bus.id_rs1 = 0; bus.id_rs2 = 0;
        bus.id_rs1_data = '0; bus.id_rs2_data = '0; bus.id_imm = '0;
        bus.id_use_pc = 0; bus.id_use_imm = 0; bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
        bus.id_alu_control = 0; bus.id_rd = 0; bus.id_reg_write = 0; bus.id_is_load = 0;
        bus.flush = 0; bus.mem_rd = 0; bus.mem_reg_write = 0; bus.mem_is_load = 0;
        bus.mem_result = '0; bus.wb_rd = 0; bus.wb_reg_write = 0; bus.wb_data = '0;
        bus.ex_ready = 0;
    endtask

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    task automatic rand_inputs();
        bus.id_valid       = ($urandom_range(0, 9) < 7);
        bus.id_pc          = r64();
        bus.id_rs1         = 5'($urandom_range(0, 7));
        bus.id_rs2         = 5'($urandom_range(0, 7));
        bus.id_rs1_data    = r64();
        bus.id_rs2_data    = r64();
        bus.id_imm         = r64();
        bus.id_use_pc      = $urandom_range(0, 3) == 0;
        bus.id_use_imm     = $urandom_range(0, 2) == 0;
        bus.id_uses_rs1    = $urandom_range(0, 3) != 0;
        bus.id_uses_rs2    = $urandom_range(0, 1) != 0;
        bus.id_alu_control = 5'($urandom);
        bus.id_rd          = 5'($urandom_range(0, 7));
        bus.id_reg_write   = $urandom_range(0, 1) != 0;
        bus.id_is_load     = $urandom_range(0, 3) == 0;
        bus.flush          = $urandom_range(0, 11) == 0;
        bus.mem_rd         = 5'($urandom_range(0, 7));
        bus.mem_reg_write  = $urandom_range(0, 3) != 0;
        bus.mem_is_load    = $urandom_range(0, 2) == 0;
        bus.mem_result     = r64();
        bus.wb_rd          = 5'($urandom_range(0, 7));
        bus.wb_reg_write   = $urandom_range(0, 3) != 0;
        bus.wb_data        = r64();
        bus.ex_ready       = $urandom_range(0, 9) < 6;
    endtask

    // One cycle: inputs already driven just after the falling edge. Check
    // outputs, advance the model across the coming rising edge, then wait.
    task automatic step();
        bit hz, exv, fire, rdy;
        logic [63:0] a1, a2;
        #1;
        hz = m_valid && bus.mem_is_load && bus.mem_reg_write && bus.mem_rd != 0 &&
             ((m_u1 && bus.mem_rd == m_rs1) || (m_u2 && bus.mem_rd == m_rs2));
        exv  = m_valid && !hz;
        fire = exv && bus.ex_ready;
        rdy  = !m_valid || fire || bus.flush;
        chk("ex_valid", 64'(bus.ex_valid), 64'(exv));
        chk("hazard_stall", 64'(bus.hazard_stall), 64'(hz));
        chk("id_ready", 64'(bus.id_ready), 64'(rdy));
`ifdef IDEX_PERF_CNT_EN
        chk("perf_hazard_cnt", 64'(perf_hazard_cnt), m_cnt);
`endif
        if (m_valid) begin
            a1 = src_val(m_rs1, m_v1);
            a2 = src_val(m_rs2, m_v2);
            chk("operand_a", bus.ex_operand_a, m_use_pc ? m_pc : a1);
            chk("operand_b", bus.ex_operand_b, m_use_imm ? m_imm : a2);
            chk("store_data", bus.ex_store_data, a2);
            chk("alu_control", 64'(bus.ex_alu_control), 64'(m_alu));
            chk("ex_pc", bus.ex_pc, m_pc);
            chk("ex_rd", 64'(bus.ex_rd), 64'(m_rd));
            chk("ex_reg_write", 64'(bus.ex_reg_write), 64'(m_rw));
            chk("ex_is_load", 64'(bus.ex_is_load), 64'(m_ld));
        end
        if (hz && m_cnt != 64'hFFFF_FFFF) m_cnt++;
        if (bus.flush) begin
            m_valid = 0;
        end else if (bus.id_valid && rdy) begin
            m_valid = 1; m_pc = bus.id_pc; m_imm = bus.id_imm;
            m_v1 = bus.id_rs1_data; m_v2 = bus.id_rs2_data;
            m_rs1 = bus.id_rs1; m_rs2 = bus.id_rs2; m_alu = bus.id_alu_control;
            m_rd = bus.id_rd; m_use_pc = bus.id_use_pc; m_use_imm = bus.id_use_imm;
            m_u1 = bus.id_uses_rs1; m_u2 = bus.id_uses_rs2;
            m_rw = bus.id_reg_write; m_ld = bus.id_is_load;
        end else if (fire) begin
            m_valid = 0;
        end else if (m_valid) begin
            // Writeback updates the architectural value of a held source.
            if (bus.wb_reg_write && bus.wb_rd != 0 && bus.wb_rd == m_rs1) m_v1 = bus.wb_data;
            if (bus.wb_reg_write && bus.wb_rd != 0 && bus.wb_rd == m_rs2) m_v2 = bus.wb_data;
        end
        @(negedge clk);
    endtask

    task automatic offer(input logic [4:0] rs1, input logic [63:0] d1,
                         input logic [4:0] rs2, input logic [63:0] d2);
        bus.id_valid = 1; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
        bus.id_rs1_data = d1; bus.id_rs2_data = d2;
        bus.id_uses_rs1 = 1; bus.id_uses_rs2 = 1; bus.id_reg_write = 1;
        bus.id_rd = 5'd9; bus.id_alu_control = 5'd1; bus.id_pc = bus.id_pc + 64'd4;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_ex_valid", 64'(bus.ex_valid), 64'd0);
        chk("rst_hazard", 64'(bus.hazard_stall), 64'd0);
        chk("rst_id_ready", 64'(bus.id_ready), 64'd1);
        @(negedge clk);
        rst = 0;

        // Back-to-back ADD x1=5, x2=7 with ex_ready high.
        bus.ex_ready = 1;
        offer(5'd1, 64'd5, 5'd2, 64'd7); step();
        offer(5'd1, 64'd5, 5'd2, 64'd7); step();
        bus.id_valid = 0; step();

        // MEM beats WB on held rs1=x3; mem_rd=0 never forwards.
        bus.ex_ready = 0;
        offer(5'd3, 64'h11, 5'd0, 64'h22); step();
        bus.id_valid = 0;
        bus.mem_rd = 3; bus.mem_reg_write = 1; bus.mem_result = 64'hAA;
        bus.wb_rd = 3; bus.wb_reg_write = 1; bus.wb_data = 64'hBB; step();
        bus.mem_rd = 0; bus.wb_reg_write = 0; step();
        bus.ex_ready = 1; bus.mem_reg_write = 0; step();

        // Load-use on rs2=x4, resolved from WB next cycle.
        offer(5'd5, 64'h1, 5'd4, 64'h2); step();
        bus.id_valid = 0;
        bus.mem_rd = 4; bus.mem_reg_write = 1; bus.mem_is_load = 1; step();
        bus.mem_reg_write = 0; bus.mem_is_load = 0;
        bus.wb_rd = 4; bus.wb_reg_write = 1; bus.wb_data = 64'h55; step();
        bus.wb_reg_write = 0; step();

        // Backpressure 3 cycles, then fire with a new capture on the same edge.
        bus.ex_ready = 0;
        offer(5'd6, 64'h66, 5'd7, 64'h77); step();
        offer(5'd1, 64'h10, 5'd2, 64'h20); step(); step(); step();
        bus.ex_ready = 1; step();
        bus.id_valid = 0; step();

        // Flush with held entry and a new offer.
        bus.ex_ready = 0;
        offer(5'd1, 64'h3, 5'd2, 64'h4); step();
        offer(5'd3, 64'h5, 5'd4, 64'h6); bus.flush = 1; step();
        bus.flush = 0; bus.id_valid = 0; bus.ex_ready = 1; step();

        // Reset asserted mid-stall takes effect without a clock edge.
        bus.ex_ready = 0;
        offer(5'd8, 64'h8, 5'd4, 64'h9); step();
        bus.id_valid = 0; bus.mem_rd = 4; bus.mem_reg_write = 1; bus.mem_is_load = 1;
        step(); step();
        #1 rst = 1;
        #1;
        chk("arst_ex_valid", 64'(bus.ex_valid), 64'd0);
        chk("arst_hazard", 64'(bus.hazard_stall), 64'd0);
        chk("arst_id_ready", 64'(bus.id_ready), 64'd1);
`ifdef IDEX_PERF_CNT_EN
        chk("arst_perf_cnt", 64'(perf_hazard_cnt), 64'd0);
`endif
        model_reset();
        @(negedge clk);
        rst = 0;
        idle_inputs();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
